// File: rtl/skeeball_game_ctrl_pkg.sv
// Shared types and constants for the skeeball front-end controller.
package skeeball_game_ctrl_pkg;

    localparam int unsigned NumHoles = 7;

    // Bit positions of each hole within sense/points.
    localparam int unsigned Hole0   = 0;
    localparam int unsigned Hole10  = 1;
    localparam int unsigned Hole20  = 2;
    localparam int unsigned Hole30  = 3;
    localparam int unsigned Hole40  = 4;
    localparam int unsigned Hole50  = 5;
    localparam int unsigned Hole100 = 6;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StPlay,
        StLockout,
        StOver
    } state_e;

    // One-hot of the highest-valued set bit; a ball landing on several sensors
    // at once scores the best hole only.
    function automatic logic [NumHoles-1:0] pick_highest(input logic [NumHoles-1:0] rises);
        logic [NumHoles-1:0] res;
        res = '0;
        if (rises[Hole100])     res[Hole100] = 1'b1;
        else if (rises[Hole50]) res[Hole50]  = 1'b1;
        else if (rises[Hole40]) res[Hole40]  = 1'b1;
        else if (rises[Hole30]) res[Hole30]  = 1'b1;
        else if (rises[Hole20]) res[Hole20]  = 1'b1;
        else if (rises[Hole10]) res[Hole10]  = 1'b1;
        else if (rises[Hole0])  res[Hole0]   = 1'b1;
        return res;
    endfunction

endpackage

// File: rtl/skeeball_game_ctrl_sensor_debounce.sv
// One hole sensor: 2-flop synchronizer, run-length debounce, accepted level
// and a strobe on the cycle the accepted level is about to rise.
module skeeball_game_ctrl_sensor_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam logic [7:0] CntLast = 8'(DEBOUNCE_CYCLES - 1);

    logic [1:0] sync_q;
    logic       level_q, level_d;
    logic [7:0] cnt_q, cnt_d;
    logic       synced;

    assign synced  = sync_q[1];
    assign level_o = level_q;

    // Count consecutive disagreeing samples; flip once the run is long enough.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        rise_o  = 1'b0;
        if (synced != level_q) begin
            if (cnt_q == CntLast) begin
                level_d = synced;
                rise_o  = synced;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // Synchronizer, accepted level and run counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], raw_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/skeeball_game_ctrl.sv
// Skeeball front end: conditions hole sensors, emits one one-hot hit pulse
// per ball, counts balls and sequences the game for the BCD scorer.
module skeeball_game_ctrl import skeeball_game_ctrl_pkg::*; #(
    parameter int unsigned NUM_BALLS       = 9,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [NumHoles-1:0] sense_i,
    output logic [NumHoles-1:0] points_o,
    output logic                playstate_o,
    output logic [3:0]          balls_left_o,
    output logic                game_over_o
);

    logic [NumHoles-1:0] level;
    logic [NumHoles-1:0] rise;
    logic [2:0]          start_sync_q;
    logic                start_rise;

    state_e              state_q, state_d;
    logic [NumHoles-1:0] points_q, points_d;
    logic [3:0]          balls_q, balls_d;
    logic                over_q, over_d;

    for (genvar g = 0; g < NumHoles; g++) begin : g_sensor
        skeeball_game_ctrl_sensor_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw_i  (sense_i[g]),
            .level_o(level[g]),
            .rise_o (rise[g])
        );
    end

    // Bit 2 holds the previous synced value, so holding start never retriggers.
    assign start_rise = start_sync_q[1] & ~start_sync_q[2];

    // Game sequencing, hit selection and ball counting.
    always_comb begin
        state_d  = state_q;
        points_d = '0;
        balls_d  = balls_q;
        over_d   = over_q;
        unique case (state_q)
            StIdle: begin
                if (start_rise) state_d = StClear;
            end
            StClear: begin
                balls_d = 4'(NUM_BALLS);
                over_d  = 1'b0;
                state_d = StPlay;
            end
            StPlay: begin
                if (|rise) begin
                    points_d = pick_highest(rise);
                    if (balls_q != 4'd0) balls_d = balls_q - 4'd1;
                    state_d  = StLockout;
                end
            end
            StLockout: begin
                // Wait for the ball to fully leave every sensor before rearming.
                if (level == '0) begin
                    if (balls_q == 4'd0) begin
                        state_d = StOver;
                        over_d  = 1'b1;
                    end else begin
                        state_d = StPlay;
                    end
                end
            end
            StOver: begin
                if (start_rise) begin
                    state_d = StClear;
                    over_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, outputs and start synchronizer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            points_q     <= '0;
            balls_q      <= '0;
            over_q       <= 1'b0;
            start_sync_q <= '0;
        end else begin
            state_q      <= state_d;
            points_q     <= points_d;
            balls_q      <= balls_d;
            over_q       <= over_d;
            start_sync_q <= {start_sync_q[1:0], start_i};
        end
    end

    assign points_o     = points_q;
    assign balls_left_o = balls_q;
    assign game_over_o  = over_q;
    // Scorer holds through LOCKOUT and OVER; only IDLE/CLEAR clear it.
    assign playstate_o  = (state_q == StPlay) || (state_q == StLockout) || (state_q == StOver);

endmodule

// File: tb/tb_skeeball_game_ctrl.sv
// Self-checking bench for skeeball_game_ctrl: directed vector table, hand
// sequences for multi-ball/reset corners, then random stimulus vs a model.
module tb_skeeball_game_ctrl;

    localparam int unsigned NB  = 9;
    localparam int unsigned DEB = 4;

    localparam int MIdle = 0, MClear = 1, MPlay = 2, MLock = 3, MOver = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_r;
    logic [6:0] sense_r;
    logic [6:0] points;
    logic       playstate;
    logic [3:0] balls_left;
    logic       game_over;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    skeeball_game_ctrl #(
        .NUM_BALLS      (NB),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_r),
        .sense_i     (sense_r),
        .points_o    (points),
        .playstate_o (playstate),
        .balls_left_o(balls_left),
        .game_over_o (game_over)
    );

    typedef struct {
        logic       start;
        logic [6:0] sense;
        logic [6:0] pts;
        logic       play;
        logic [3:0] balls;
        logic       over;
    } vec_t;

    vec_t vecs[$];

    // Reference model: raw input histories plus game-level bookkeeping.
    logic [6:0] sense_hist[$];
    logic       start_hist[$];
    logic [6:0] m_acc;
    logic [6:0] m_points;
    int         m_mode;
    int         m_balls;
    bit         model_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [12:0] dut_vec();
        return {points, playstate, balls_left, game_over};
    endfunction

    function automatic logic [12:0] model_vec();
        logic play;
        play = (m_mode == MPlay) || (m_mode == MLock) || (m_mode == MOver);
        return {m_points, play, 4'(m_balls), (m_mode == MOver)};
    endfunction

    task automatic model_reset();
        sense_hist.delete();
        start_hist.delete();
        for (int i = 0; i < int'(DEB) + 4; i++) begin
            sense_hist.push_back(7'd0);
            start_hist.push_back(1'b0);
        end
        m_acc    = '0;
        m_points = '0;
        m_mode   = MIdle;
        m_balls  = 0;
    endtask

    // A sensor's accepted level flips once its last DEB synced samples (raw
    // delayed two clocks) all disagree with it.
    task automatic model_edge(input logic st, input logic [6:0] sn);
        int         n;
        logic [6:0] acc_new, rises, s;
        logic       srise, all_diff;
        sense_hist.push_back(sn);
        start_hist.push_back(st);
        n = sense_hist.size();
        for (int b = 0; b < 7; b++) begin
            all_diff = 1'b1;
            for (int j = 0; j < int'(DEB); j++) begin
                s = sense_hist[n - 3 - j];
                if (s[b] == m_acc[b]) all_diff = 1'b0;
            end
            acc_new[b] = all_diff ? ~m_acc[b] : m_acc[b];
        end
        rises    = acc_new & ~m_acc;
        srise    = start_hist[n - 3] & ~start_hist[n - 4];
        m_points = '0;
        case (m_mode)
            MIdle:  if (srise) m_mode = MClear;
            MClear: begin
                m_balls = NB;
                m_mode  = MPlay;
            end
            MPlay: begin
                if (rises != 0) begin
                    for (int b = 0; b < 7; b++) if (rises[b]) m_points = 7'(1 << b);
                    if (m_balls > 0) m_balls--;
                    m_mode = MLock;
                end
            end
            MLock: if (m_acc == 0) m_mode = (m_balls == 0) ? MOver : MPlay;
            MOver:  if (srise) m_mode = MClear;
            default: m_mode = MIdle;
        endcase
        m_acc = acc_new;
    endtask

    task automatic tick();
        @(posedge clk);
        if (model_on) model_edge(start_r, sense_r);
        #1;
    endtask

    task automatic add_vec(input int n, input logic st, input logic [6:0] sn,
                           input logic [6:0] pts, input logic play,
                           input logic [3:0] balls, input logic over);
        vec_t v;
        v.start = st; v.sense = sn; v.pts = pts; v.play = play; v.balls = balls; v.over = over;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    // One ball on the gutter sensor; reports pulse count and last nonzero pulse.
    task automatic gutter_ball(output int pulses, output logic [6:0] last_pts);
        pulses   = 0;
        last_pts = '0;
        for (int i = 0; i < 18; i++) begin
            sense_r = (i < 8) ? 7'h01 : 7'h00;
            tick();
            if (points != 0) begin
                pulses++;
                last_pts = points;
            end
        end
    endtask

    // Press start for 3 cycles; counts cycles the scorer is told to clear.
    task automatic start_press(output int zeros);
        zeros = 0;
        for (int i = 0; i < 8; i++) begin
            start_r = (i < 3);
            tick();
            if (!playstate) zeros++;
        end
        start_r = 1'b0;
    endtask

    initial begin
        int         pulses, total, zeros, cyc, kind, len;
        logic [6:0] lp, mask;

        rst_n   = 1'b0;
        start_r = 1'b0;
        sense_r = '0;

        // Directed vectors: start game, single hit, bounce, simultaneous hit.
        add_vec(3, 1'b1, 7'h00, 7'h00, 1'b0, 4'd0, 1'b0);
        add_vec(2, 1'b0, 7'h00, 7'h00, 1'b1, 4'd9, 1'b0);
        add_vec(5, 1'b0, 7'h08, 7'h00, 1'b1, 4'd9, 1'b0);
        add_vec(1, 1'b0, 7'h08, 7'h08, 1'b1, 4'd8, 1'b0);
        add_vec(4, 1'b0, 7'h08, 7'h00, 1'b1, 4'd8, 1'b0);
        add_vec(7, 1'b0, 7'h00, 7'h00, 1'b1, 4'd8, 1'b0);
        for (int i = 0; i < 20; i++)
            add_vec(1, 1'b0, (i % 2 == 0) ? 7'h10 : 7'h00, 7'h00, 1'b1, 4'd8, 1'b0);
        add_vec(6, 1'b0, 7'h00, 7'h00, 1'b1, 4'd8, 1'b0);
        add_vec(5, 1'b0, 7'h42, 7'h00, 1'b1, 4'd8, 1'b0);
        add_vec(1, 1'b0, 7'h42, 7'h40, 1'b1, 4'd7, 1'b0);
        add_vec(2, 1'b0, 7'h42, 7'h00, 1'b1, 4'd7, 1'b0);
        add_vec(8, 1'b0, 7'h00, 7'h00, 1'b1, 4'd7, 1'b0);

        #1;
        check("reset_outputs", 32'(dut_vec()), 32'd0);
        tick();
        tick();
        check("reset_hold", 32'(dut_vec()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            start_r = vecs[i].start;
            sense_r = vecs[i].sense;
            tick();
            check($sformatf("vec%0d", i), 32'(dut_vec()),
                  32'({vecs[i].pts, vecs[i].play, vecs[i].balls, vecs[i].over}));
        end
        start_r = 1'b0;
        sense_r = '0;

        // Finish the current game with seven gutter balls.
        for (int b = 0; b < 7; b++) begin
            gutter_ball(pulses, lp);
            check("finish_ball_pulses", 32'(pulses), 32'd1);
        end
        check("finish_over", 32'({game_over, playstate, balls_left}), 32'({1'b1, 1'b1, 4'd0}));

        // New game, nine gutter balls, then another restart.
        start_press(zeros);
        check("restart1_clear_cycles", 32'(zeros), 32'd1);
        check("restart1_balls", 32'({playstate, game_over, balls_left}), 32'({1'b1, 1'b0, 4'd9}));
        total = 0;
        for (int b = 0; b < 9; b++) begin
            gutter_ball(pulses, lp);
            total += pulses;
            check("gutter_pts", 32'(lp), 32'h01);
        end
        check("gutter_total", 32'(total), 32'd9);
        check("gutter_over", 32'({game_over, playstate, balls_left}), 32'({1'b1, 1'b1, 4'd0}));
        gutter_ball(pulses, lp);
        check("over_ignores_sensors", 32'(pulses), 32'd0);
        start_press(zeros);
        check("restart2_clear_cycles", 32'(zeros), 32'd1);
        check("restart2_balls", 32'({playstate, game_over, balls_left}), 32'({1'b1, 1'b0, 4'd9}));

        // Async reset while locked out on a 50 hit.
        pulses = 0;
        sense_r = 7'h20;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (points != 0) begin
                pulses++;
                lp = points;
            end
        end
        check("lock_hit", 32'({lp, 4'(pulses), balls_left}), 32'({7'h20, 4'd1, 4'd8}));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 32'(dut_vec()), 32'd0);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 48; i++) begin
            sense_r = ((i / 8) % 2 == 1) ? 7'h7f : 7'h00;
            tick();
            check("idle_after_reset", 32'({points, playstate}), 32'd0);
        end

        // Randomized play against the reference model.
        rst_n   = 1'b0;
        sense_r = '0;
        start_r = 1'b0;
        tick();
        tick();
        model_reset();
        @(negedge clk);
        rst_n    = 1'b1;
        model_on = 1'b1;
        cyc      = 0;
        while (cyc < 4000) begin
            kind = $urandom_range(0, 7);
            len  = $urandom_range(1, 12);
            mask = 7'($urandom_range(1, 127));
            for (int i = 0; i < len; i++) begin
                if (kind <= 3)      sense_r = mask;
                else if (kind <= 5) sense_r = 7'($urandom_range(0, 127));
                else                sense_r = '0;
                if ($urandom_range(0, 29) == 0) start_r = ~start_r;
                tick();
                check("random", 32'(dut_vec()), 32'(model_vec()));
                cyc++;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
